// File: rtl/fast_pow_pkg.sv
// rtl/fast_pow_pkg.sv - shared types and sizing helpers for the modular exponentiation unit
package fast_pow_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        TEST,
        MUL,
        SQR,
        FIN
    } state_t;

    // Two guard bits keep 2r + x below 2^(WIDTH+2) for any modulus below 2^WIDTH.
    function automatic int modmul_bits(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - interleaved (Blakley) bit-serial modular multiplier, WIDTH steps per product
module mod_mul_serial
    import fast_pow_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             rdy
);

    localparam int MB = modmul_bits(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    logic [MB-1:0]    r;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] mr;
    logic [CW-1:0]    cnt;
    logic             active;

    // One MSB-first step: r = 2r + bit*x, then fold back below m (or wrap when m = 0).
    function automatic logic [MB-1:0] step(input logic [MB-1:0]    rv,
                                           input logic [WIDTH-1:0] xv,
                                           input logic             bit_i,
                                           input logic [WIDTH-1:0] mv);
        logic [MB-1:0] t;
        logic [MB-1:0] mz;
        mz = {2'b00, mv};
        t  = {rv[MB-2:0], 1'b0} + (bit_i ? {2'b00, xv} : '0);
        if (mv == '0) begin
            return {2'b00, t[WIDTH-1:0]};
        end
        if (t >= mz) t = t - mz;
        if (t >= mz) t = t - mz;
        return t;
    endfunction

    // The go cycle already performs the first step, so rdy follows exactly WIDTH edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r      <= '0;
            xr     <= '0;
            yr     <= '0;
            mr     <= '0;
            cnt    <= '0;
            active <= 1'b0;
            rdy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                r      <= step('0, x, y[WIDTH-1], m);
                xr     <= x;
                yr     <= y << 1;
                mr     <= m;
                cnt    <= CW'(WIDTH - 1);
                active <= 1'b1;
            end else if (active) begin
                r  <= step(r, xr, yr[WIDTH-1], mr);
                yr <= yr << 1;
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    rdy    <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign p = r[WIDTH-1:0];

endmodule

// File: rtl/fast_pow_mod.sv
// rtl/fast_pow_mod.sv - start/done accelerator computing a^b mod m by right-to-left square-and-multiply
module fast_pow_mod
    import fast_pow_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [EXP_WIDTH-1:0] b,
    input  logic [WIDTH-1:0]     m,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy
);

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     mod;
    logic [EXP_WIDTH-1:0] expo;
    logic                 exp_more;

    logic                 mm_go;
    logic                 mm_rdy;
    logic [WIDTH-1:0]     mm_x;
    logic [WIDTH-1:0]     mm_y;
    logic [WIDTH-1:0]     mm_p;

    assign exp_more = (expo >> 1) != '0;

    // Operands only matter in the go cycle; the multiplier captures them there.
    always_comb begin
        mm_x = acc;
        mm_y = base;
        case (state)
            REDUCE:  mm_x = WIDTH'(1);
            SQR:     mm_x = base;
            default: mm_x = acc;
        endcase
    end

    mod_mul_serial #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (mm_go),
        .x       (mm_x),
        .y       (mm_y),
        .m       (mod),
        .p       (mm_p),
        .rdy     (mm_rdy)
    );

    // mm_go is raised on the edge that enters a multiplying state so no cycle is spent launching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            base   <= '0;
            mod    <= '0;
            expo   <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            mm_go  <= 1'b0;
        end else begin
            mm_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        base  <= a;
                        expo  <= b;
                        mod   <= m;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        mm_go <= 1'b1;
                        state <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (mm_rdy) begin
                        base  <= mm_p;
                        acc   <= (mod == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state <= TEST;
                    end
                end
                TEST: begin
                    if (expo == '0) begin
                        state <= FIN;
                    end else if (expo[0]) begin
                        mm_go <= 1'b1;
                        state <= MUL;
                    end else begin
                        mm_go <= 1'b1;
                        state <= SQR;
                    end
                end
                MUL: begin
                    if (mm_rdy) begin
                        acc   <= mm_p;
                        mm_go <= exp_more;
                        state <= SQR;
                    end
                end
                SQR: begin
                    // The final square would never be used, so it is skipped.
                    if (!exp_more) begin
                        expo  <= '0;
                        state <= FIN;
                    end else if (mm_rdy) begin
                        base  <= mm_p;
                        expo  <= expo >> 1;
                        state <= TEST;
                    end
                end
                FIN: begin
                    result <= acc;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
